// File: rtl/hazard_pkg.sv
// Shared types and constants for the IF|DE|MW hazard controller.
// No logic here; consumed by hazard_ctrl and hazard_fwd_match.
// No flow control.
package hazard_pkg;

  // Controller states: normal issue, load-use bubble, waiting on data memory.
  typedef enum logic [1:0] {
    HZ_RUN     = 2'd0,
    HZ_LU      = 2'd1,
    HZ_MEMWAIT = 2'd2
  } hz_state_t;

  // Architectural zero register; writes to it are discarded, so it never forwards.
  localparam int unsigned REG_ZERO = 0;

endpackage : hazard_pkg

// File: rtl/hazard_fwd_match.sv
// Compares one DE source register against the MW destination register.
// Purely combinational, zero cycles.
// No flow control.
module hazard_fwd_match
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_rs,
  input  logic              i_use_rs,
  input  logic [REG_AW-1:0] i_rd,
  input  logic              i_reg_wr,
  output logic              o_match
);

  localparam logic [REG_AW-1:0] RD_ZERO = REG_AW'(REG_ZERO);

  logic w_rd_nonzero;
  logic w_rd_eq_rs;

  assign w_rd_nonzero = (i_rd != RD_ZERO);
  assign w_rd_eq_rs   = (i_rd == i_rs);

  // Match only when the DE instruction actually reads the register and MW really writes it.
  assign o_match = i_use_rs & i_reg_wr & w_rd_nonzero & w_rd_eq_rs;

endmodule : hazard_fwd_match

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the IF|DE|MW pipeline: forward selects, stalls, flushes, perf count.
// All control outputs are combinational from inputs and state (same cycle); counters update next edge.
// Holds the pipeline while data memory is not ready; load-use inserts one bubble into MW.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [REG_AW-1:0] i_rs1_de,
  input  logic [REG_AW-1:0] i_rs2_de,
  input  logic              i_use_rs1_de,
  input  logic              i_use_rs2_de,
  input  logic              i_br_taken_de,
  input  logic [REG_AW-1:0] i_rd_mw,
  input  logic              i_reg_wr_mw,
  input  logic              i_is_load_mw,
  input  logic              i_dmem_req_mw,
  input  logic              i_dmem_ready,
  output logic              o_forward_ae,
  output logic              o_forward_be,
  output logic              o_stall_if,
  output logic              o_stall_de,
  output logic              o_stall_mw,
  output logic              o_flush_de,
  output logic              o_flush_mw,
  output logic              o_mem_err,
  output logic [CNT_W-1:0]  o_stall_cycles
);

  // Wait counter must be able to hold MEM_TIMEOUT itself (its saturation value).
  localparam int                WCNT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(MEM_TIMEOUT);
  localparam logic [WCNT_W-1:0] WAIT_ERR = WCNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  hz_state_t         r_state;
  hz_state_t         w_state_nxt;
  logic [WCNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0]  r_stall_cycles;
  logic              r_mem_err;

  logic w_match_a;
  logic w_match_b;
  logic w_mem_stall;
  logic w_fwd_ok;

  logic w_stall_if;
  logic w_stall_de;
  logic w_stall_mw;
  logic w_flush_de;
  logic w_flush_mw;
  logic w_wait_start;
  logic w_wait_inc;
  logic w_wait_clr;
  logic w_err_set;

  hazard_fwd_match #(
    .REG_AW (REG_AW)
  ) u_match_a (
    .i_rs     (i_rs1_de),
    .i_use_rs (i_use_rs1_de),
    .i_rd     (i_rd_mw),
    .i_reg_wr (i_reg_wr_mw),
    .o_match  (w_match_a)
  );

  hazard_fwd_match #(
    .REG_AW (REG_AW)
  ) u_match_b (
    .i_rs     (i_rs2_de),
    .i_use_rs (i_use_rs2_de),
    .i_rd     (i_rd_mw),
    .i_reg_wr (i_reg_wr_mw),
    .o_match  (w_match_b)
  );

  assign w_mem_stall = i_dmem_req_mw & ~i_dmem_ready;

  // Loads never forward: their data is not ready in MW, so the load-use bubble covers them and
  // the write-first regfile supplies the value after the stall. Forwarding is also suppressed
  // whenever the pipeline is not freely advancing.
  assign w_fwd_ok = (r_state == HZ_RUN) & ~w_mem_stall & ~i_is_load_mw;

  // Next-state and stall/flush decode; priority in RUN is memory wait, then load-use, then branch.
  always_comb begin
    w_state_nxt  = r_state;
    w_stall_if   = 1'b0;
    w_stall_de   = 1'b0;
    w_stall_mw   = 1'b0;
    w_flush_de   = 1'b0;
    w_flush_mw   = 1'b0;
    w_wait_start = 1'b0;
    w_wait_inc   = 1'b0;
    w_wait_clr   = 1'b0;
    w_err_set    = 1'b0;
    unique case (r_state)
      HZ_RUN: begin
        if (w_mem_stall) begin
          w_stall_if   = 1'b1;
          w_stall_de   = 1'b1;
          w_stall_mw   = 1'b1;
          w_wait_start = 1'b1;
          w_state_nxt  = HZ_MEMWAIT;
        end else if (i_is_load_mw & (w_match_a | w_match_b)) begin
          w_stall_if  = 1'b1;
          w_stall_de  = 1'b1;
          w_flush_mw  = 1'b1;
          w_state_nxt = HZ_LU;
        end else if (i_br_taken_de) begin
          w_flush_de = 1'b1;
        end
      end
      HZ_LU: begin
        // Bubble occupies MW, so no memory access can be pending; only a branch matters.
        w_flush_de  = i_br_taken_de;
        w_state_nxt = HZ_RUN;
      end
      HZ_MEMWAIT: begin
        // Branches wait: the DE instruction is re-evaluated once the pipeline moves again.
        if (!i_dmem_ready) begin
          w_stall_if = 1'b1;
          w_stall_de = 1'b1;
          w_stall_mw = 1'b1;
          w_wait_inc = 1'b1;
          w_err_set  = (r_wait_cnt == WAIT_ERR);
        end else begin
          w_wait_clr  = 1'b1;
          w_state_nxt = HZ_RUN;
        end
      end
      default: begin
        w_state_nxt = HZ_RUN;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= HZ_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Memory wait counter: starts at 1 on entry, saturates at MEM_TIMEOUT, clears on completion.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait_cnt <= '0;
    end else if (w_wait_start) begin
      r_wait_cnt <= WCNT_W'(1);
    end else if (w_wait_clr) begin
      r_wait_cnt <= '0;
    end else if (w_wait_inc && (r_wait_cnt != WAIT_MAX)) begin
      r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
    end
  end

  // Sticky timeout flag; only reset clears it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem_err <= 1'b0;
    end else if (w_err_set) begin
      r_mem_err <= 1'b1;
    end
  end

  // Saturating perf counter of cycles in which the front end is held.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cycles <= '0;
    end else if (w_stall_if && (r_stall_cycles != CNT_MAX)) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  // Combinational outputs are gated by reset so nothing leaks out while the block is held in reset.
  assign o_forward_ae   = i_rst_n & w_match_a & w_fwd_ok;
  assign o_forward_be   = i_rst_n & w_match_b & w_fwd_ok;
  assign o_stall_if     = i_rst_n & w_stall_if;
  assign o_stall_de     = i_rst_n & w_stall_de;
  assign o_stall_mw     = i_rst_n & w_stall_mw;
  assign o_flush_de     = i_rst_n & w_flush_de;
  assign o_flush_mw     = i_rst_n & w_flush_mw;
  assign o_mem_err      = r_mem_err;
  assign o_stall_cycles = r_stall_cycles;

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, memory wait, timeout, branch, reset.
// Inputs change on the falling edge; outputs are checked 1ns later, before the next rising edge.
// Control outputs are compared as one packed vector {fa,fb,sif,sde,smw,fde,fmw,err}.
module tb_hazard_ctrl;

  localparam int REG_AW      = 5;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [REG_AW-1:0] rs1_de, rs2_de, rd_mw;
  logic              use_rs1_de, use_rs2_de, br_taken_de;
  logic              reg_wr_mw, is_load_mw, dmem_req_mw, dmem_ready;
  logic              forward_ae, forward_be, stall_if, stall_de, stall_mw;
  logic              flush_de, flush_mw, mem_err;
  logic [CNT_W-1:0]  stall_cycles;

  int tests_run    = 0;
  int tests_failed = 0;

  wire [7:0] ctl = {forward_ae, forward_be, stall_if, stall_de, stall_mw,
                    flush_de, flush_mw, mem_err};

  always #5 clk = ~clk;

  hazard_ctrl #(
    .REG_AW      (REG_AW),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_rs1_de       (rs1_de),
    .i_rs2_de       (rs2_de),
    .i_use_rs1_de   (use_rs1_de),
    .i_use_rs2_de   (use_rs2_de),
    .i_br_taken_de  (br_taken_de),
    .i_rd_mw        (rd_mw),
    .i_reg_wr_mw    (reg_wr_mw),
    .i_is_load_mw   (is_load_mw),
    .i_dmem_req_mw  (dmem_req_mw),
    .i_dmem_ready   (dmem_ready),
    .o_forward_ae   (forward_ae),
    .o_forward_be   (forward_be),
    .o_stall_if     (stall_if),
    .o_stall_de     (stall_de),
    .o_stall_mw     (stall_mw),
    .o_flush_de     (flush_de),
    .o_flush_mw     (flush_mw),
    .o_mem_err      (mem_err),
    .o_stall_cycles (stall_cycles)
  );

  task automatic set_de(input logic [REG_AW-1:0] rs1, input logic u1,
                        input logic [REG_AW-1:0] rs2, input logic u2, input logic br);
    rs1_de = rs1; use_rs1_de = u1; rs2_de = rs2; use_rs2_de = u2; br_taken_de = br;
  endtask

  task automatic set_mw(input logic [REG_AW-1:0] rd, input logic wr, input logic ld,
                        input logic req, input logic rdy);
    rd_mw = rd; reg_wr_mw = wr; is_load_mw = ld; dmem_req_mw = req; dmem_ready = rdy;
  endtask

  task automatic idle();
    set_de(5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    set_mw(5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_de(5'd5, 1'b1, 5'd5, 1'b1, 1'b1);
    set_mw(5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    tests_run++;
    if (ctl !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_ctl: got %b want %b", ctl, 8'h00);
    end
    tests_run++;
    if (stall_cycles !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_cnt: got %0d want 0", stall_cycles);
    end
    @(negedge clk);
    idle();
    rst_n = 1'b1;
  endtask

  task automatic test_forward();
    do_reset();
    @(negedge clk);
    set_de(5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    set_mw(5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    tests_run++;
    if (ctl !== 8'h80) begin
      tests_failed++;
      $display("FAIL fwd_rs1: got %b want %b", ctl, 8'h80);
    end
    @(negedge clk);
    set_de(5'd3, 1'b1, 5'd5, 1'b1, 1'b0);
    #1;
    tests_run++;
    if (ctl !== 8'h40) begin
      tests_failed++;
      $display("FAIL fwd_rs2: got %b want %b", ctl, 8'h40);
    end
    @(negedge clk);
    set_de(5'd5, 1'b0, 5'd5, 1'b1, 1'b0);
    reg_wr_mw = 1'b0;
    #1;
    tests_run++;
    if (ctl !== 8'h00) begin
      tests_failed++;
      $display("FAIL fwd_no_wr: got %b want %b", ctl, 8'h00);
    end
    @(negedge clk);
    set_de(5'd0, 1'b1, 5'd9, 1'b1, 1'b0);
    set_mw(5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    tests_run++;
    if (ctl !== 8'h00) begin
      tests_failed++;
      $display("FAIL fwd_x0: got %b want %b", ctl, 8'h00);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    @(negedge clk);
    set_de(5'd1, 1'b1, 5'd7, 1'b1, 1'b0);
    set_mw(5'd7, 1'b1, 1'b1, 1'b1, 1'b1);
    #1;
    tests_run++;
    if (ctl !== 8'h32) begin
      tests_failed++;
      $display("FAIL lu_stall: got %b want %b", ctl, 8'h32);
    end
    @(negedge clk);
    set_mw(5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    tests_run++;
    if (ctl !== 8'h00) begin
      tests_failed++;
      $display("FAIL lu_bubble: got %b want %b", ctl, 8'h00);
    end
    tests_run++;
    if (stall_cycles !== 8'd1) begin
      tests_failed++;
      $display("FAIL lu_cnt: got %0d want 1", stall_cycles);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (ctl !== 8'h40) begin
      tests_failed++;
      $display("FAIL lu_back_run: got %b want %b", ctl, 8'h40);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      set_de(5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
      set_mw(5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
      #1;
      tests_run++;
      if (ctl !== 8'h38 || stall_cycles !== k[CNT_W-1:0]) begin
        tests_failed++;
        $display("FAIL memwait_c%0d: got ctl %b cnt %0d want ctl %b cnt %0d",
                 k, ctl, stall_cycles, 8'h38, k);
      end
    end
    @(negedge clk);
    dmem_ready = 1'b1;
    #1;
    tests_run++;
    if (ctl !== 8'h00 || stall_cycles !== 8'd3) begin
      tests_failed++;
      $display("FAIL memwait_ready: got ctl %b cnt %0d want ctl %b cnt 3", ctl, stall_cycles, 8'h00);
    end
    @(negedge clk);
    idle();
    #1;
    tests_run++;
    if (stall_cycles !== 8'd3) begin
      tests_failed++;
      $display("FAIL memwait_cnt_hold: got %0d want 3", stall_cycles);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] exp;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      set_mw(5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      #1;
      exp = (k >= 4) ? 8'h39 : 8'h38;
      tests_run++;
      if (ctl !== exp) begin
        tests_failed++;
        $display("FAIL timeout_c%0d: got %b want %b", k, ctl, exp);
      end
    end
    @(negedge clk);
    dmem_ready = 1'b1;
    #1;
    tests_run++;
    if (ctl !== 8'h01 || stall_cycles !== 8'd6) begin
      tests_failed++;
      $display("FAIL timeout_ready: got ctl %b cnt %0d want ctl %b cnt 6", ctl, stall_cycles, 8'h01);
    end
    @(negedge clk);
    idle();
    #1;
    tests_run++;
    if (ctl !== 8'h01) begin
      tests_failed++;
      $display("FAIL timeout_sticky: got %b want %b", ctl, 8'h01);
    end
  endtask

  task automatic test_branch_priority();
    do_reset();
    @(negedge clk);
    set_de(5'd8, 1'b1, 5'd0, 1'b0, 1'b1);
    set_mw(5'd8, 1'b1, 1'b1, 1'b1, 1'b1);
    #1;
    tests_run++;
    if (ctl !== 8'h32) begin
      tests_failed++;
      $display("FAIL br_vs_lu: got %b want %b", ctl, 8'h32);
    end
    @(negedge clk);
    set_mw(5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    tests_run++;
    if (ctl !== 8'h04) begin
      tests_failed++;
      $display("FAIL br_in_lu: got %b want %b", ctl, 8'h04);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      set_mw(5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
      #1;
      tests_run++;
      if (ctl !== 8'h38) begin
        tests_failed++;
        $display("FAIL br_memwait_c%0d: got %b want %b", k, ctl, 8'h38);
      end
    end
    @(negedge clk);
    dmem_ready = 1'b1;
    #1;
    tests_run++;
    if (ctl !== 8'h00) begin
      tests_failed++;
      $display("FAIL br_mem_ready: got %b want %b", ctl, 8'h00);
    end
    @(negedge clk);
    set_mw(5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    tests_run++;
    if (ctl !== 8'h04) begin
      tests_failed++;
      $display("FAIL br_after_mem: got %b want %b", ctl, 8'h04);
    end
  endtask

  task automatic test_reset_in_memwait();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      set_mw(5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (ctl !== 8'h00 || stall_cycles !== 8'd0) begin
      tests_failed++;
      $display("FAIL rst_memwait: got ctl %b cnt %0d want ctl %b cnt 0", ctl, stall_cycles, 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_de(5'd4, 1'b1, 5'd0, 1'b0, 1'b0);
    set_mw(5'd4, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    tests_run++;
    if (ctl !== 8'h80) begin
      tests_failed++;
      $display("FAIL rst_release_run: got %b want %b", ctl, 8'h80);
    end
  endtask

  task automatic test_back_to_back_saturate();
    do_reset();
    @(negedge clk);
    set_mw(5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (300) @(negedge clk);
    #1;
    tests_run++;
    if (stall_cycles !== 8'hFF) begin
      tests_failed++;
      $display("FAIL sat_cnt: got %0d want 255", stall_cycles);
    end
    @(negedge clk);
    dmem_ready = 1'b1;
    @(negedge clk);
    idle();
    #1;
    tests_run++;
    if (ctl !== 8'h01 || stall_cycles !== 8'hFF) begin
      tests_failed++;
      $display("FAIL sat_hold: got ctl %b cnt %0d want ctl %b cnt 255", ctl, stall_cycles, 8'h01);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_forward();
    test_load_use();
    test_mem_wait();
    test_timeout();
    test_branch_priority();
    test_reset_in_memwait();
    test_back_to_back_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_hazard_ctrl
